// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among N requesters.
// A grant is held from arbitration until the owner's last beat is written.
module fifo_wr_arbiter #(
   parameter int N  = 4,
   parameter int DW = 104,
   parameter int PW = $clog2(N)
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [N-1:0]    in_valid,
   input  logic [N*DW-1:0] in_data,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_wait,
   input  logic            fifo_full,
   input  logic            fifo_prog_full,
   output logic            fifo_wr_en,
   output logic [DW-1:0]   fifo_din,
   output logic [N-1:0]    grant,
   output logic            busy
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   logic [N-1:0]  winner_oh;
   logic [PW-1:0] owner_idx;
   logic [PW-1:0] ptr_after_owner;
   logic          owner_valid;
   logic          owner_last;
   logic          xfer;
   logic [DW-1:0] data_masked [N];

   // Search rr_ptr, rr_ptr+1, ... modulo N; the first valid requester wins.
   always_comb begin
      logic [PW:0] idx;
      logic        found;
      winner_oh = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(N)) begin
            idx = idx - (PW+1)'(N);
         end
         if (!found && in_valid[idx[PW-1:0]]) begin
            winner_oh[idx[PW-1:0]] = 1'b1;
            found                  = 1'b1;
         end
      end
   end

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            owner_idx = PW'(i);
         end
      end
   end

   assign ptr_after_owner = (owner_idx == PW'(N-1)) ? '0 : owner_idx + PW'(1);

   // grant_q is one-hot in LOCK, so these reductions select the owner's bit.
   assign owner_valid = |(grant_q & in_valid);
   assign owner_last  = |(grant_q & in_last);
   assign xfer        = (state_q == LOCK) && owner_valid && !fifo_full;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign data_masked[gi] = in_data[gi*DW +: DW] & {DW{grant_q[gi]}};
      end
   endgenerate

   always_comb begin
      fifo_din = '0;
      for (int i = 0; i < N; i++) begin
         fifo_din = fifo_din | data_masked[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if ((|in_valid) && !fifo_prog_full) begin
               state_d = LOCK;
               grant_d = winner_oh;
            end
         end
         LOCK: begin
            // prog_full is deliberately ignored here: a started packet only yields to full.
            if (xfer && owner_last) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = ptr_after_owner;
            end
         end
         default: begin
            state_d  = IDLE;
            grant_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign fifo_wr_en = xfer;
   assign grant      = grant_q;
   assign busy       = (state_q == LOCK);
   assign in_wait    = ~(grant_q & {N{!fifo_full}});

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, hand-written corner sequences
// and a randomized phase, all compared against a packet-level reference model.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            nreset;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_wait;
   logic            fifo_full;
   logic            fifo_prog_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_din;
   logic [N-1:0]    grant;
   logic            busy;

   fifo_wr_arbiter #(.N(N), .DW(DW)) dut (
      .clk(clk), .nreset(nreset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_wait(in_wait),
      .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: current packet owner (-1 when none) and next requester to favour.
   int m_owner;
   int m_ptr;
   // Traffic sources: each requester walks through packets of src_len beats.
   int src_len [N];
   int src_beat[N];
   int src_pkt [N];
   bit rand_len;
   // Observations collected at each check point.
   logic [DW-1:0] wr_log[$];
   int            busy_cnt;

   typedef struct {
      logic [N-1:0]  v;
      logic          f;
      logic          pf;
      logic [N-1:0]  g;
      logic          w;
      logic          b;
      logic [DW-1:0] d;
   } vec_t;
   vec_t tbl[14];

   function automatic logic [DW-1:0] beat_word(int i);
      return {4'(i), 4'(src_pkt[i]), 8'(src_beat[i])};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic f, input logic pf);
      in_valid       = v;
      fifo_full      = f;
      fifo_prog_full = pf;
      for (int i = 0; i < N; i++) begin
         in_data[i*DW +: DW] = beat_word(i);
         in_last[i]          = (src_beat[i] == src_len[i] - 1);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0]  eg, ew_n;
      logic          ewr, eb;
      logic [DW-1:0] ed;
      eg   = '0;
      ewr  = 1'b0;
      eb   = (m_owner >= 0);
      ed   = '0;
      ew_n = '1;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ewr = in_valid[m_owner] && !fifo_full;
         ed  = in_data[m_owner*DW +: DW];
         if (!fifo_full) ew_n[m_owner] = 1'b0;
      end
      check({tag, ".grant"},   32'(grant),      32'(eg));
      check({tag, ".wr_en"},   32'(fifo_wr_en), 32'(ewr));
      check({tag, ".din"},     32'(fifo_din),   32'(ed));
      check({tag, ".in_wait"}, 32'(in_wait),    32'(ew_n));
      check({tag, ".busy"},    32'(busy),       32'(eb));
      if (fifo_wr_en) wr_log.push_back(fifo_din);
      if (busy) busy_cnt++;
   endtask

   task automatic model_step();
      int o;
      if (m_owner >= 0) begin
         o = m_owner;
         if (in_valid[o] && !fifo_full) begin
            if (in_last[o]) begin
               m_ptr       = (o + 1) % N;
               m_owner     = -1;
               src_beat[o] = 0;
               src_pkt[o]++;
               if (rand_len) src_len[o] = $urandom_range(1, 4);
            end else begin
               src_beat[o]++;
            end
         end
      end else if ((|in_valid) && !fifo_prog_full) begin
         for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) begin
               m_owner = (m_ptr + k) % N;
               break;
            end
         end
      end
   endtask

   task automatic at_neg(input string tag);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic at_pos();
      @(posedge clk);
      model_step();
      #1;
      drive(in_valid, fifo_full, fifo_prog_full);
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_ptr    = 0;
      rand_len = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_len[i]  = 2;
         src_beat[i] = 0;
         src_pkt[i]  = 0;
      end
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      model_reset();
      drive('0, 1'b0, 1'b0);
      #1;
      check("reset.grant",   32'(grant),      32'h0);
      check("reset.wr_en",   32'(fifo_wr_en), 32'h0);
      check("reset.busy",    32'(busy),       32'h0);
      check("reset.in_wait", 32'(in_wait),    32'hF);
      check("reset.din",     32'(fifo_din),   32'h0);
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;
      wr_log.delete();
      busy_cnt = 0;
   endtask

   initial begin
      logic [N-1:0] prev_g;
      logic [N-1:0] g_seq[$];
      int           t_seq[$];
      logic [N-1:0] v;

      do_reset();

      // ---------- table-driven vectors ----------
      for (int i = 0; i < N; i++) src_len[i] = 3;
      tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h0000};
      tbl[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h0001};
      tbl[3]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h0002};
      tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[5]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[6]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h1000};
      tbl[7]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h1001};
      tbl[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h1002};
      tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[10] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[11] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[12] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 16'h0100};
      tbl[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h0100};
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].v, tbl[i].f, tbl[i].pf);
         at_neg($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d.grant", i), 32'(grant),      32'(tbl[i].g));
         check($sformatf("tbl%0d.wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].w));
         check($sformatf("tbl%0d.busy", i),  32'(busy),       32'(tbl[i].b));
         check($sformatf("tbl%0d.din", i),   32'(fifo_din),   32'(tbl[i].d));
         $display("vec %0d: valid=%b full=%b pf=%b grant=%b wr_en=%b din=%h",
                  i, tbl[i].v, tbl[i].f, tbl[i].pf, grant, fifo_wr_en, fifo_din);
         at_pos();
      end

      // ---------- round-robin rotation with 2-beat packets ----------
      do_reset();
      drive(4'b1111, 1'b0, 1'b0);
      prev_g = '0;
      for (int c = 0; c < 30; c++) begin
         at_neg("rot");
         if (grant != '0 && prev_g == '0) begin
            g_seq.push_back(grant);
            t_seq.push_back(c);
         end
         prev_g = grant;
         at_pos();
      end
      check("rot.count_ok", 32'(g_seq.size() >= 5), 32'h1);
      if (g_seq.size() >= 5) begin
         check("rot.g0", 32'(g_seq[0]), 32'h1);
         check("rot.g1", 32'(g_seq[1]), 32'h2);
         check("rot.g2", 32'(g_seq[2]), 32'h4);
         check("rot.g3", 32'(g_seq[3]), 32'h8);
         check("rot.g4", 32'(g_seq[4]), 32'h1);
         check("rot.gap", 32'(t_seq[1] - t_seq[0]), 32'd3);
         check("rot.period", 32'(t_seq[4] - t_seq[0]), 32'd12);
         $display("rotation: grants %b %b %b %b %b, period %0d",
                  g_seq[0], g_seq[1], g_seq[2], g_seq[3], g_seq[4], t_seq[4] - t_seq[0]);
      end

      // ---------- fifo_full for 2 cycles on beat 2 of a 4-beat packet ----------
      do_reset();
      src_len[0] = 4;
      for (int c = 0; c < 8; c++) begin
         drive((c < 7) ? 4'b0001 : 4'b0000, (c == 2 || c == 3), 1'b0);
         at_neg("full");
         if (c == 2 || c == 3) begin
            check("full.wr_en_low", 32'(fifo_wr_en), 32'h0);
            check("full.owner_wait", 32'(in_wait[0]), 32'h1);
         end
         at_pos();
      end
      check("full.lock_cycles", 32'(busy_cnt), 32'd6);
      check("full.beats", 32'(wr_log.size()), 32'd4);
      for (int b = 0; b < 4 && b < wr_log.size(); b++)
         check($sformatf("full.beat%0d", b), 32'(wr_log[b]), 32'(b));
      $display("full stall: %0d beats, %0d lock cycles", wr_log.size(), busy_cnt);

      // ---------- prog_full gating in IDLE, ignored in LOCK ----------
      do_reset();
      src_len[2] = 3;
      for (int c = 0; c < 9; c++) begin
         drive(4'b0100, 1'b0, (c < 4) || (c >= 6));
         at_neg("pfull");
         if (c <= 4) check("pfull.no_grant", 32'(grant), 32'h0);
         if (c == 5) check("pfull.grant", 32'(grant), 32'h4);
         at_pos();
      end
      check("pfull.beats", 32'(wr_log.size()), 32'd3);
      $display("prog_full: %0d beats written", wr_log.size());

      // ---------- owner bubble while another requester waits ----------
      do_reset();
      src_len[0] = 4;
      src_len[1] = 2;
      for (int c = 0; c < 9; c++) begin
         v = (c >= 2 && c <= 4) ? 4'b0010 : 4'b0011;
         drive(v, 1'b0, 1'b0);
         at_neg("bubble");
         if (c >= 2 && c <= 4) begin
            check("bubble.grant_held", 32'(grant), 32'h1);
            check("bubble.no_write", 32'(fifo_wr_en), 32'h0);
            check("bubble.other_wait", 32'(in_wait[1]), 32'h1);
         end
         at_pos();
      end
      check("bubble.beats", 32'(wr_log.size() >= 4), 32'h1);
      for (int b = 0; b < 4 && b < wr_log.size(); b++)
         check($sformatf("bubble.beat%0d", b), 32'(wr_log[b]), 32'(b));
      $display("bubble: %0d beats written", wr_log.size());

      // ---------- asynchronous reset during beat 2 of requester 2 ----------
      do_reset();
      src_len[2] = 4;
      drive(4'b0100, 1'b0, 1'b0);
      at_neg("arst");
      at_pos();
      at_neg("arst");
      at_pos();
      at_neg("arst");
      check("arst.pre_grant", 32'(grant), 32'h4);
      #2;
      nreset = 1'b0;
      #1;
      check("arst.grant",   32'(grant),      32'h0);
      check("arst.wr_en",   32'(fifo_wr_en), 32'h0);
      check("arst.busy",    32'(busy),       32'h0);
      check("arst.in_wait", 32'(in_wait),    32'hF);
      model_reset();
      @(posedge clk);
      #1;
      nreset = 1'b1;
      drive(4'b1100, 1'b0, 1'b0);
      at_neg("arst2");
      at_pos();
      at_neg("arst2");
      check("arst.restart_grant", 32'(grant), 32'h4);
      at_pos();
      $display("async reset: restart grant %b", grant);

      // ---------- randomized traffic against the model ----------
      do_reset();
      rand_len = 1'b1;
      for (int i = 0; i < N; i++) src_len[i] = $urandom_range(1, 4);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 6);
         drive(v, ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) < 3));
         at_neg("rand");
         at_pos();
      end
      $display("random: %0d beats written", wr_log.size());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
